// File: rtl/bram_fifo_stream_reader.sv
// bram_fifo_stream_reader: turns a 1-cycle-latency BRAM FIFO read port into a
// full-throughput valid/ready stream. Optional FIFO_STREAM_READER_TLAST_EN adds PKT_LEN / m_last.
module bram_fifo_stream_reader #(
    parameter int DATA_WIDTH = 32
`ifdef FIFO_STREAM_READER_TLAST_EN
    ,
    parameter int PKT_LEN = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_STREAM_READER_TLAST_EN
    output logic                  m_last,
`endif
    output logic [1:0]            occupancy
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic [2:0]            pending;

    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid && m_ready;
    assign m_data    = head;
    assign occupancy = occ;

    // Words that will sit in the buffer next cycle; a new read only if a slot stays free.
    assign pending    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = !rst && !fifo_empty && (pending < 3'd2);

    // Track the read whose data returns on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Two-entry buffer: head is the presented word, tail the one behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            unique case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= fifo_data;
                    end else begin
                        tail <= fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= fifo_data;
                    end else begin
                        head <= tail;
                        tail <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_TLAST_EN
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    logic [CW-1:0] beat_cnt;

    // Count accepted beats modulo PKT_LEN to mark packet boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    assign m_last = m_valid && (beat_cnt == LAST_BEAT);
`endif

endmodule

// File: tb/tb_bram_fifo_stream_reader.sv
// tb_bram_fifo_stream_reader: FIFO model with 1-cycle read latency, scoreboard of
// FIFO-order words, monitor checking every handshake and stream hold rules.
module tb_bram_fifo_stream_reader;

    localparam int DW = 32;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;
`ifdef FIFO_STREAM_READER_TLAST_EN
    logic          m_last;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int beats = 0;
    int hs_cnt = 0;
    int first_hs = -1;
    int last_hs = -1;
    logic rd = 1'b0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          prst = 1'b1;
    logic [DW-1:0] pd = '0;
    logic [DW-1:0] exp_w;

`ifdef FIFO_STREAM_READER_TLAST_EN
    bram_fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .PKT_LEN(PL)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .occupancy(occupancy)
    );
`else
    bram_fifo_stream_reader #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .occupancy(occupancy)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive inputs at the falling edge and sample the resulting read request.
    task automatic drive(input logic r, input logic rdy);
        @(negedge clk);
        rst = r;
        m_ready = rdy;
        if (r) begin
            fq.delete();
            sb.delete();
            beats = 0;
        end
        fifo_empty = (fq.size() == 0);
        #1;
        rd = fifo_rd_en;
        check("rd_while_empty", DW'(rd && fifo_empty), '0);
    endtask

    // Rising edge: FIFO returns the word requested in the cycle just ended.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
    endtask

    task automatic preload(input logic [DW-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    task automatic drain(input int maxc, input bit random_ready);
        int k;
        k = 0;
        while ((sb.size() != 0 || fq.size() != 0) && k < maxc) begin
            drive(1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            tick();
            k++;
        end
        check("drain_left", DW'(sb.size()), '0);
    endtask

    // Monitor: every handshake is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !prst && pv && !pr) begin
                check("hold_valid", DW'(m_valid), DW'(1));
                check("hold_data", m_data, pd);
            end
            if (!rst && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", m_data, 'x);
                end else begin
                    exp_w = sb.pop_front();
                    check("beat_data", m_data, exp_w);
                end
`ifdef FIFO_STREAM_READER_TLAST_EN
                check("m_last", DW'(m_last), DW'((beats % PL) == PL - 1));
`endif
                beats++;
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            pv = m_valid;
            pr = m_ready;
            prst = rst;
            pd = m_data;
        end
    end

    initial begin
        // Reset and first-word latency
        drive(1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b1);
        check("rst_valid", DW'(m_valid), '0);
        check("rst_rd_en", DW'(fifo_rd_en), '0);
        check("rst_occ", DW'(occupancy), '0);
        check("rst_data", m_data, '0);
        tick();
        preload(32'hA5);
        drive(1'b0, 1'b1);
        check("lat_rd_en", DW'(rd), DW'(1));
        check("lat_valid_n0", DW'(m_valid), '0);
        tick();
        drive(1'b0, 1'b1);
        check("lat_valid_n1", DW'(m_valid), '0);
        tick();
        drive(1'b0, 1'b1);
        check("lat_valid_n2", DW'(m_valid), DW'(1));
        check("lat_data_n2", m_data, 32'hA5);
        tick();
        drive(1'b0, 1'b1);
        check("lat_occ_after", DW'(occupancy), '0);
        tick();

        // Full-rate streaming
        hs_cnt = 0;
        first_hs = -1;
        for (int i = 1; i <= 100; i++) preload(DW'(i));
        for (int i = 0; i < 110; i++) begin
            drive(1'b0, 1'b1);
            tick();
        end
        check("stream_count", DW'(hs_cnt), DW'(100));
        check("stream_span", DW'(last_hs - first_hs), DW'(99));
        check("stream_left", DW'(sb.size()), '0);

        // Backpressure
        for (int i = 1; i <= 10; i++) preload(DW'(i));
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0);
        check("bp_occ", DW'(occupancy), DW'(2));
        check("bp_rd_en", DW'(rd), '0);
        check("bp_valid", DW'(m_valid), DW'(1));
        check("bp_data", m_data, DW'(1));
        tick();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            drive(1'b0, 1'(i % 2));
            tick();
        end
        check("bp_left", DW'(sb.size()), '0);
        drain(20, 1'b0);

        // Capture and pop in the same cycle with one word buffered
        preload(32'hAAAA0001);
        preload(32'hBBBB0002);
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1);
        check("sim_occ_before", DW'(occupancy), DW'(1));
        check("sim_data_before", m_data, 32'hAAAA0001);
        tick();
        drive(1'b0, 1'b0);
        check("sim_occ_after", DW'(occupancy), DW'(1));
        check("sim_data_after", m_data, 32'hBBBB0002);
        tick();
        drain(20, 1'b0);

        // Reset with a word buffered and another in flight
        for (int i = 0; i < 5; i++) preload(32'h200 + DW'(i));
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0);
        check("mid_occ_pre", DW'(occupancy), DW'(1));
        tick();
        drive(1'b0, 1'b0);
        check("mid_valid", DW'(m_valid), '0);
        check("mid_occ", DW'(occupancy), '0);
        check("mid_data", m_data, '0);
        tick();
        for (int i = 0; i < 4; i++) preload(32'h300 + DW'(i));
        drain(30, 1'b0);

        // Packet framing from a clean counter, then with random stalls
        drive(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) preload(32'h400 + DW'(i));
        drain(30, 1'b0);
        for (int i = 0; i < 8; i++) preload(32'h500 + DW'(i));
        drain(80, 1'b1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) != 0));
            tick();
            if (!rst && $urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) preload($urandom);
            end
        end
        drain(600, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
